// File: rtl/multi_phase_signal_controller_if.sv
// Bus between the sensor/preempt front end (master) and the signal controller (slave).
// The front end drives demand and preempt requests; the controller returns lamp states.
interface multi_phase_signal_controller_if #(
    parameter int NUM_PHASES = 3
);
    localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;

    logic [NUM_PHASES-1:0] phase_req;
    logic                  preempt;
    logic [PW-1:0]         preempt_phase;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] red;
    logic [PW-1:0]         cur_phase;
    logic                  preempt_active;

    modport master (
        output phase_req, preempt, preempt_phase,
        input  green, yellow, red, cur_phase, preempt_active
    );

    modport slave (
        input  phase_req, preempt, preempt_phase,
        output green, yellow, red, cur_phase, preempt_active
    );
endinterface

// File: rtl/multi_phase_signal_controller.sv
// N-phase intersection signal controller.
// Cycles GREEN -> YELLOW -> ALL-RED, picks the next phase round-robin on demand,
// optionally rests in green, and serves emergency preemption.
module multi_phase_signal_controller #(
    parameter int NUM_PHASES    = 3,
    parameter int CNT_W         = 32,
    parameter int T_GREEN       = 5_000_000,
    parameter int T_YELLOW      = 2_000_000,
    parameter int T_ALLRED      = 500_000,
    parameter int REST_IN_GREEN = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    multi_phase_signal_controller_if.slave        bus
);
    localparam int PW  = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
    localparam int PW1 = PW + 1;

    localparam logic [1:0] ST_ALLRED = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [PW:0]      PHASES_EXT  = PW1'(NUM_PHASES);
    localparam bit               REST_EN     = (REST_IN_GREEN != 32'sd0);

    logic [1:0]            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [PW-1:0]         cur_phase_r;
    logic [PW-1:0]         nxt_phase_r;
    logic                  preempt_active_r;

    logic                  preempt_valid_s;
    logic                  preempt_hold_s;
    logic [NUM_PHASES-1:0] cur_mask_s;
    logic                  other_req_s;
    logic                  green_done_s;

    // First requesting phase after cur (wrapping); falls back to cur+1 when nobody asks.
    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] cur,
                                              input logic [NUM_PHASES-1:0] req);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        logic          found;
        pick  = PW'((int'(cur) + 1) % NUM_PHASES);
        found = 1'b0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            idx = PW'((int'(cur) + k) % NUM_PHASES);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Preempt qualification, competing demand and green-dwell completion.
    always_comb begin
        preempt_valid_s = bus.preempt && ({1'b0, bus.preempt_phase} < PHASES_EXT);
        preempt_hold_s  = preempt_valid_s && (bus.preempt_phase == cur_phase_r);
        cur_mask_s      = NUM_PHASES'(1'b1) << cur_phase_r;
        other_req_s     = |(bus.phase_req & ~cur_mask_s);
        green_done_s    = (cnt_r >= GREEN_LAST);
    end

    // Phase sequencer: state, dwell counter, served and next phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ALLRED;
            cnt_r       <= '0;
            cur_phase_r <= '0;
            nxt_phase_r <= '0;
        end else begin
            case (state_r)
                ST_GREEN: begin
                    if (preempt_hold_s) begin
                        cnt_r <= '0;
                    end else if (preempt_valid_s ||
                                 (green_done_s && (!REST_EN || other_req_s))) begin
                        state_r     <= ST_YELLOW;
                        cnt_r       <= '0;
                        nxt_phase_r <= rr_next(cur_phase_r, bus.phase_req);
                    end else if (green_done_s) begin
                        cnt_r <= GREEN_LAST;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_YELLOW: begin
                    if (cnt_r == YELLOW_LAST) begin
                        state_r <= ST_ALLRED;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_ALLRED: begin
                    if (cnt_r == ALLRED_LAST) begin
                        state_r     <= ST_GREEN;
                        cnt_r       <= '0;
                        cur_phase_r <= preempt_valid_s ? bus.preempt_phase : nxt_phase_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_ALLRED;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Preempt flag: raised on any valid request, dropped once a green sees it released.
    always_ff @(posedge clk) begin
        if (rst) begin
            preempt_active_r <= 1'b0;
        end else if (preempt_valid_s) begin
            preempt_active_r <= 1'b1;
        end else if (state_r == ST_GREEN) begin
            preempt_active_r <= 1'b0;
        end else begin
            preempt_active_r <= preempt_active_r;
        end
    end

    // Lamp decode straight from registered state so lamps switch with the state.
    always_comb begin
        bus.green  = '0;
        bus.yellow = '0;
        bus.red    = '1;
        case (state_r)
            ST_GREEN: begin
                bus.green[cur_phase_r] = 1'b1;
                bus.red[cur_phase_r]   = 1'b0;
            end
            ST_YELLOW: begin
                bus.yellow[cur_phase_r] = 1'b1;
                bus.red[cur_phase_r]    = 1'b0;
            end
            default: begin
                bus.red = '1;
            end
        endcase
    end

    assign bus.cur_phase      = cur_phase_r;
    assign bus.preempt_active = preempt_active_r;

endmodule

// File: tb/tb_multi_phase_signal_controller.sv
// Directed bench for the multi-phase signal controller: one instance without and one
// with rest-in-green, 3 phases, short dwell times (G=8, Y=3, AR=2).
module tb_multi_phase_signal_controller;
    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   inv_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multi_phase_signal_controller_if #(.NUM_PHASES(NP)) bus0 ();
    multi_phase_signal_controller_if #(.NUM_PHASES(NP)) bus1 ();

    multi_phase_signal_controller #(
        .NUM_PHASES(NP), .CNT_W(32), .T_GREEN(8), .T_YELLOW(3), .T_ALLRED(2),
        .REST_IN_GREEN(0)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    multi_phase_signal_controller #(
        .NUM_PHASES(NP), .CNT_W(32), .T_GREEN(8), .T_YELLOW(3), .T_ALLRED(2),
        .REST_IN_GREEN(1)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {preempt_active, cur_phase, green, yellow, red}
    function automatic logic [11:0] obs(input int sel);
        if (sel == 0)
            return {bus0.preempt_active, bus0.cur_phase, bus0.green, bus0.yellow, bus0.red};
        else
            return {bus1.preempt_active, bus1.cur_phase, bus1.green, bus1.yellow, bus1.red};
    endfunction

    function automatic logic lamp_ok(input logic [2:0] g, input logic [2:0] y, input logic [2:0] r);
        logic ok;
        ok = $onehot0(g | y);
        for (int i = 0; i < NP; i++) begin
            if ((int'(g[i]) + int'(y[i]) + int'(r[i])) != 1) ok = 1'b0;
        end
        return ok;
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            check_eq("inv0", 32'(lamp_ok(bus0.green, bus0.yellow, bus0.red)), 32'd1);
            check_eq("inv1", 32'(lamp_ok(bus1.green, bus1.yellow, bus1.red)), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input int sel, input logic pa, input int cur,
                          input logic [2:0] g, input logic [2:0] y, input logic [2:0] r);
        logic [1:0] c;
        c = 2'(cur);
        check_eq(tag, 32'(obs(sel)), 32'({pa, c, g, y, r}));
    endtask

    task automatic run_green(input string tag, input int sel, input int n, input int p, input logic pa);
        logic [2:0] one;
        one = 3'b001 << p;
        for (int i = 0; i < n; i++) begin
            sample(tag, sel, pa, p, one, 3'b000, ~one);
            tick();
        end
    endtask

    task automatic run_yellow(input string tag, input int sel, input int n, input int p, input logic pa);
        logic [2:0] one;
        one = 3'b001 << p;
        for (int i = 0; i < n; i++) begin
            sample(tag, sel, pa, p, 3'b000, one, ~one);
            tick();
        end
    endtask

    task automatic run_red(input string tag, input int sel, input int n, input int cur, input logic pa);
        for (int i = 0; i < n; i++) begin
            sample(tag, sel, pa, cur, 3'b000, 3'b000, 3'b111);
            tick();
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus0.phase_req = 3'b000; bus0.preempt = 1'b0; bus0.preempt_phase = 2'd0;
        bus1.phase_req = 3'b000; bus1.preempt = 1'b0; bus1.preempt_phase = 2'd0;

        // 1: fixed cycle with no demand
        reset_dut();
        inv_en = 1'b1;
        run_red   ("t1_ar0", 0, 2, 0, 1'b0);
        run_green ("t1_g0",  0, 8, 0, 1'b0);
        run_yellow("t1_y0",  0, 3, 0, 1'b0);
        run_red   ("t1_ar1", 0, 2, 0, 1'b0);
        run_green ("t1_g1",  0, 8, 1, 1'b0);
        run_yellow("t1_y1",  0, 1, 1, 1'b0);

        // 5: reset pulse in the middle of yellow[1]
        rst = 1'b1;
        tick();
        sample("t5_rst", 0, 1'b0, 0, 3'b000, 3'b000, 3'b111);
        rst = 1'b0;
        tick();
        run_red  ("t5_ar", 0, 1, 0, 1'b0);
        run_green("t5_g0", 0, 1, 0, 1'b0);

        // 2: demand on phase 2 skips phase 1
        bus0.phase_req = 3'b100;
        reset_dut();
        run_red   ("t2_ar0", 0, 2, 0, 1'b0);
        run_green ("t2_g0",  0, 8, 0, 1'b0);
        run_yellow("t2_y0",  0, 3, 0, 1'b0);
        run_red   ("t2_ar1", 0, 2, 0, 1'b0);
        run_green ("t2_g2",  0, 1, 2, 1'b0);
        bus0.phase_req = 3'b000;
        run_green ("t2_g2b", 0, 7, 2, 1'b0);
        run_yellow("t2_y2",  0, 1, 2, 1'b0);

        // 4: preempt to phase 2 at green[0] cycle 3, held green, release
        reset_dut();
        run_red  ("t4_ar0", 0, 2, 0, 1'b0);
        run_green("t4_g0",  0, 2, 0, 1'b0);
        sample("t4_g0c3", 0, 1'b0, 0, 3'b001, 3'b000, 3'b110);
        bus0.preempt = 1'b1;
        bus0.preempt_phase = 2'd2;
        tick();
        run_yellow("t4_y0",   0, 3, 0, 1'b1);
        run_red   ("t4_ar",   0, 2, 0, 1'b1);
        run_green ("t4_hold", 0, 20, 2, 1'b1);
        bus0.preempt = 1'b0;
        run_green ("t4_drop", 0, 1, 2, 1'b1);
        run_green ("t4_rel",  0, 7, 2, 1'b0);
        run_yellow("t4_y2",   0, 1, 2, 1'b0);

        // 6: out-of-range preempt phase is ignored
        bus0.preempt = 1'b1;
        bus0.preempt_phase = 2'd3;
        reset_dut();
        run_red   ("t6_ar0", 0, 2, 0, 1'b0);
        run_green ("t6_g0",  0, 8, 0, 1'b0);
        run_yellow("t6_y0",  0, 3, 0, 1'b0);
        run_red   ("t6_ar1", 0, 2, 0, 1'b0);
        run_green ("t6_g1",  0, 1, 1, 1'b0);
        bus0.preempt = 1'b0;
        bus0.preempt_phase = 2'd0;

        // 3: rest-in-green holds phase 0 until another phase asks
        reset_dut();
        run_red  ("t3_ar0",  1, 2, 0, 1'b0);
        run_green("t3_rest", 1, 60, 0, 1'b0);
        bus1.phase_req = 3'b010;
        run_green ("t3_last", 1, 1, 0, 1'b0);
        run_yellow("t3_y0",   1, 3, 0, 1'b0);
        run_red   ("t3_ar1",  1, 2, 0, 1'b0);
        run_green ("t3_g1",   1, 12, 1, 1'b0);

        inv_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
